// File: rtl/torreta_disparador.sv
`default_nettype none
// ============================================================================
// Module      : torreta_disparador
// Description : Trigger mechanism of the turret. It sequences the trigger
//               servo through arm / fire / re-cock dwells, generates the
//               servo PWM and keeps the magazine round count.
// Revision    : 1.0 - initial release
// ============================================================================
module torreta_disparador #(
    parameter int unsigned T_ARMAR      = 25000000,
    parameter int unsigned T_DISPARO    = 15000000,
    parameter int unsigned T_RECARGA    = 25000000,
    parameter int unsigned PERIODO_PWM  = 1000000,
    parameter int unsigned LARG_REPOUSO = 50000,
    parameter int unsigned LARG_ARMADO  = 75000,
    parameter int unsigned LARG_DISPARO = 100000,
    parameter int unsigned MUNICAO_MAX  = 6
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       armar_disparo,
    input  logic       disparar,
    input  logic       recarregar_disparo,
    input  logic       recarregar_municao,
    output logic       disparo_pronto,
    output logic       fim_disparo,
    output logic       disparo_carregado,
    output logic       municao_carregada,
    output logic [3:0] municao,
    output logic       pwm_gatilho,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        REPOUSO      = 4'd0,
        ARMANDO      = 4'd1,
        ARMADO       = 4'd2,
        DISPARANDO   = 4'd3,
        DISPARADO    = 4'd4,
        RECARREGANDO = 4'd5,
        CARREGADO    = 4'd6
    } estado_t;

    localparam logic [3:0] c_municao_max = 4'(MUNICAO_MAX);

    estado_t     r_estado;
    estado_t     w_proximo;
    logic [31:0] r_timer;
    logic        w_dwell_fim;
    logic        r_disparo_pronto;
    logic        r_fim_disparo;
    logic        r_disparo_carregado;
    logic [3:0]  r_municao;
    logic [31:0] r_pwm_cnt;
    logic [31:0] r_larg;
    logic [31:0] w_larg_req;
    logic [31:0] w_larg_eff;
    logic        r_pwm;

    // Dwell-complete detection: the last cycle of each timed state
    always_comb begin
        w_dwell_fim = 1'b0;
        case (r_estado)
            ARMANDO:      w_dwell_fim = (r_timer == T_ARMAR - 1);
            DISPARANDO:   w_dwell_fim = (r_timer == T_DISPARO - 1);
            RECARREGANDO: w_dwell_fim = (r_timer == T_RECARGA - 1);
            default:      w_dwell_fim = 1'b0;
        endcase
    end

    // Next-state decision; disparar outranks armar, which outranks recarregar
    always_comb begin
        w_proximo = r_estado;
        case (r_estado)
            REPOUSO: begin
                if (disparar)                w_proximo = DISPARANDO;
                else if (armar_disparo)      w_proximo = ARMANDO;
                else if (recarregar_disparo) w_proximo = RECARREGANDO;
            end
            ARMANDO: begin
                if (w_dwell_fim)                       w_proximo = ARMADO;
                else if (!armar_disparo && !disparar)  w_proximo = REPOUSO;
            end
            ARMADO: begin
                if (disparar)            w_proximo = DISPARANDO;
                else if (!armar_disparo) w_proximo = REPOUSO;
            end
            // The servo stroke is mechanical: once started it always completes
            DISPARANDO: begin
                if (w_dwell_fim) w_proximo = DISPARADO;
            end
            DISPARADO: begin
                if (recarregar_disparo) w_proximo = RECARREGANDO;
                else if (!disparar)     w_proximo = REPOUSO;
            end
            RECARREGANDO: begin
                if (w_dwell_fim)              w_proximo = CARREGADO;
                else if (!recarregar_disparo) w_proximo = REPOUSO;
            end
            CARREGADO: begin
                if (!recarregar_disparo) w_proximo = REPOUSO;
            end
            default: w_proximo = REPOUSO;
        endcase
    end

    // Sequencer: state, dwell timer, registered status flags and round count
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado            <= REPOUSO;
            r_timer             <= '0;
            r_disparo_pronto    <= 1'b0;
            r_fim_disparo       <= 1'b0;
            r_disparo_carregado <= 1'b0;
            r_municao           <= c_municao_max;
        end else begin
            r_estado <= w_proximo;
            if (w_proximo != r_estado)
                r_timer <= '0;
            else if (r_estado == ARMANDO || r_estado == DISPARANDO ||
                     r_estado == RECARREGANDO)
                r_timer <= r_timer + 32'd1;
            else
                r_timer <= '0;

            r_disparo_pronto    <= (r_estado == ARMADO);
            r_fim_disparo       <= (r_estado == DISPARADO);
            r_disparo_carregado <= (r_estado == CARREGADO);

            // A refill on the same edge as a shot leaves the magazine full
            if (recarregar_municao)
                r_municao <= c_municao_max;
            else if (r_estado == DISPARANDO && w_proximo == DISPARADO &&
                     r_municao != 4'd0)
                r_municao <= r_municao - 4'd1;
        end
    end

    // Servo position requested by the current state
    always_comb begin
        case (r_estado)
            ARMANDO, ARMADO:       w_larg_req = LARG_ARMADO;
            DISPARANDO, DISPARADO: w_larg_req = LARG_DISPARO;
            default:               w_larg_req = LARG_REPOUSO;
        endcase
        // At the period boundary the freshly latched width is already in use
        w_larg_eff = (r_pwm_cnt == 32'd0) ? w_larg_req : r_larg;
    end

    // PWM: width latched only at period start so no period is ever truncated
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pwm_cnt <= '0;
            r_larg    <= LARG_REPOUSO;
            r_pwm     <= 1'b0;
        end else begin
            r_pwm_cnt <= (r_pwm_cnt == PERIODO_PWM - 1) ? 32'd0 : r_pwm_cnt + 32'd1;
            if (r_pwm_cnt == 32'd0)
                r_larg <= w_larg_req;
            r_pwm <= (r_pwm_cnt < w_larg_eff);
        end
    end

    assign disparo_pronto    = r_disparo_pronto;
    assign fim_disparo       = r_fim_disparo;
    assign disparo_carregado = r_disparo_carregado;
    assign municao           = r_municao;
    assign municao_carregada = (r_municao != 4'd0);
    assign pwm_gatilho       = r_pwm;
    assign db_estado         = r_estado;

endmodule
`default_nettype wire

// File: tb/tb_torreta_disparador.sv
`default_nettype none
// ============================================================================
// Module      : tb_torreta_disparador
// Description : Self-checking bench for torreta_disparador. State changes are
//               checked against a queue of expected db_estado codes pushed as
//               stimulus is applied; timing, ammunition and PWM are checked
//               inline by each scenario task.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_torreta_disparador;

    localparam int c_t_armar   = 4;
    localparam int c_t_disparo = 3;
    localparam int c_t_recarga = 5;

    logic       clock;
    logic       reset;
    logic       armar_disparo;
    logic       disparar;
    logic       recarregar_disparo;
    logic       recarregar_municao;
    logic       disparo_pronto;
    logic       fim_disparo;
    logic       disparo_carregado;
    logic       municao_carregada;
    logic [3:0] municao;
    logic       pwm_gatilho;
    logic [3:0] db_estado;

    int         n_cmp = 0;
    int         n_err = 0;
    int         exp_q[$];
    bit         mon_en = 1'b0;
    logic [3:0] mon_prev;

    torreta_disparador #(
        .T_ARMAR     (c_t_armar),
        .T_DISPARO   (c_t_disparo),
        .T_RECARGA   (c_t_recarga),
        .PERIODO_PWM (20),
        .LARG_REPOUSO(2),
        .LARG_ARMADO (3),
        .LARG_DISPARO(4),
        .MUNICAO_MAX (2)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .armar_disparo     (armar_disparo),
        .disparar          (disparar),
        .recarregar_disparo(recarregar_disparo),
        .recarregar_municao(recarregar_municao),
        .disparo_pronto    (disparo_pronto),
        .fim_disparo       (fim_disparo),
        .disparo_carregado (disparo_carregado),
        .municao_carregada (municao_carregada),
        .municao           (municao),
        .pwm_gatilho       (pwm_gatilho),
        .db_estado         (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Scoreboard consumer: every state change must match the next queued code
    always @(negedge clock) begin
        if (mon_en && db_estado !== mon_prev) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL state_seq: got %0d, no state change expected", db_estado);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (db_estado !== 4'(e)) begin
                    n_err++;
                    $display("FAIL state_seq: got %0d, expected %0d", db_estado, e);
                end
            end
            mon_prev = db_estado;
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic refill;
        recarregar_municao = 1'b1;
        tick;
        recarregar_municao = 1'b0;
    endtask

    // Arm, fire and re-cock once; latencies are counted from the sampling edge
    task automatic do_cycle(output int lat_p, output int lat_f, output int lat_c);
        int n;
        armar_disparo = 1'b1;
        exp_q.push_back(1); exp_q.push_back(2);
        n = 0;
        do begin tick; n++; end while (!disparo_pronto && n < 40);
        lat_p = disparo_pronto ? n - 1 : -1;
        armar_disparo = 1'b0; disparar = 1'b1;
        exp_q.push_back(3); exp_q.push_back(4);
        n = 0;
        do begin tick; n++; end while (!fim_disparo && n < 40);
        lat_f = fim_disparo ? n - 1 : -1;
        disparar = 1'b0; recarregar_disparo = 1'b1;
        exp_q.push_back(5); exp_q.push_back(6);
        n = 0;
        do begin tick; n++; end while (!disparo_carregado && n < 40);
        lat_c = disparo_carregado ? n - 1 : -1;
        recarregar_disparo = 1'b0;
        exp_q.push_back(0);
        tick; tick;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick; tick;
        n_cmp += 7;
        if (db_estado !== 4'd0) begin n_err++; $display("FAIL rst_estado: got %0d, expected 0", db_estado); end
        if (disparo_pronto !== 1'b0) begin n_err++; $display("FAIL rst_pronto: got %b, expected 0", disparo_pronto); end
        if (fim_disparo !== 1'b0) begin n_err++; $display("FAIL rst_fim: got %b, expected 0", fim_disparo); end
        if (disparo_carregado !== 1'b0) begin n_err++; $display("FAIL rst_carregado: got %b, expected 0", disparo_carregado); end
        if (municao_carregada !== 1'b1) begin n_err++; $display("FAIL rst_mun_carregada: got %b, expected 1", municao_carregada); end
        if (municao !== 4'd2) begin n_err++; $display("FAIL rst_municao: got %0d, expected 2", municao); end
        if (pwm_gatilho !== 1'b0) begin n_err++; $display("FAIL rst_pwm: got %b, expected 0", pwm_gatilho); end
        reset = 1'b0;
        tick;
        mon_prev = db_estado;
        mon_en   = 1'b1;
    endtask

    task automatic test_full_cycle;
        int lp, lf, lc;
        do_cycle(lp, lf, lc);
        n_cmp += 4;
        if (lp !== 1 + c_t_armar) begin n_err++; $display("FAIL lat_pronto: got %0d, expected %0d", lp, 1 + c_t_armar); end
        if (lf !== 1 + c_t_disparo) begin n_err++; $display("FAIL lat_fim: got %0d, expected %0d", lf, 1 + c_t_disparo); end
        if (lc !== 1 + c_t_recarga) begin n_err++; $display("FAIL lat_carregado: got %0d, expected %0d", lc, 1 + c_t_recarga); end
        if (municao !== 4'd1) begin n_err++; $display("FAIL full_municao: got %0d, expected 1", municao); end
    endtask

    task automatic test_ammo_depletion;
        int lp, lf, lc;
        refill;
        n_cmp++;
        if (municao !== 4'd2) begin n_err++; $display("FAIL ammo_refill0: got %0d, expected 2", municao); end
        do_cycle(lp, lf, lc);
        n_cmp++;
        if (municao !== 4'd1) begin n_err++; $display("FAIL ammo_shot1: got %0d, expected 1", municao); end
        do_cycle(lp, lf, lc);
        n_cmp += 2;
        if (municao !== 4'd0) begin n_err++; $display("FAIL ammo_shot2: got %0d, expected 0", municao); end
        if (municao_carregada !== 1'b0) begin n_err++; $display("FAIL ammo_empty_flag: got %b, expected 0", municao_carregada); end
        do_cycle(lp, lf, lc);
        n_cmp += 2;
        if (municao !== 4'd0) begin n_err++; $display("FAIL ammo_saturate: got %0d, expected 0", municao); end
        if (lf !== 1 + c_t_disparo) begin n_err++; $display("FAIL ammo_empty_fire_lat: got %0d, expected %0d", lf, 1 + c_t_disparo); end
        refill;
        n_cmp += 2;
        if (municao !== 4'd2) begin n_err++; $display("FAIL ammo_refill: got %0d, expected 2", municao); end
        if (municao_carregada !== 1'b1) begin n_err++; $display("FAIL ammo_full_flag: got %b, expected 1", municao_carregada); end
    endtask

    task automatic test_refill_race;
        int n;
        armar_disparo = 1'b1;
        exp_q.push_back(1); exp_q.push_back(2);
        n = 0;
        do begin tick; n++; end while (!disparo_pronto && n < 40);
        armar_disparo = 1'b0; disparar = 1'b1;
        exp_q.push_back(3); exp_q.push_back(4);
        tick; tick; tick;
        recarregar_municao = 1'b1;
        tick;
        recarregar_municao = 1'b0;
        n_cmp += 2;
        if (db_estado !== 4'd4) begin n_err++; $display("FAIL race_estado: got %0d, expected 4", db_estado); end
        if (municao !== 4'd2) begin n_err++; $display("FAIL race_municao: got %0d, expected 2", municao); end
        disparar = 1'b0;
        exp_q.push_back(0);
        tick; tick;
    endtask

    task automatic test_abort;
        int n;
        bit seen;
        armar_disparo = 1'b1;
        exp_q.push_back(1); exp_q.push_back(0);
        tick; tick;
        armar_disparo = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin tick; seen |= disparo_pronto; end
        n_cmp++;
        if (seen !== 1'b0) begin n_err++; $display("FAIL abort_pronto: got 1, expected 0"); end
        disparar = 1'b1;
        exp_q.push_back(3); exp_q.push_back(4); exp_q.push_back(0);
        tick;
        disparar = 1'b0;
        n = 0;
        while (db_estado !== 4'd4 && n < 20) begin tick; n++; end
        n_cmp += 2;
        if (n !== c_t_disparo) begin n_err++; $display("FAIL drop_dwell: got %0d, expected %0d", n, c_t_disparo); end
        if (municao !== 4'd1) begin n_err++; $display("FAIL drop_municao: got %0d, expected 1", municao); end
        tick; tick;
    endtask

    task automatic test_pwm;
        int n, h;
        logic prev;
        prev = pwm_gatilho;
        n = 0;
        do begin prev = pwm_gatilho; tick; n++; end while (!(pwm_gatilho && !prev) && n < 60);
        n_cmp++;
        if (n >= 60) begin n_err++; $display("FAIL pwm_sync1: got no period start, expected one within 60"); end
        // Enter ARMANDO in the middle of a period that started at rest width
        armar_disparo = 1'b1;
        exp_q.push_back(1); exp_q.push_back(2);
        h = 1;
        for (int i = 0; i < 19; i++) begin tick; h += int'(pwm_gatilho); end
        n_cmp++;
        if (h !== 2) begin n_err++; $display("FAIL pwm_cur_period: got %0d high, expected 2", h); end
        h = 0;
        for (int i = 0; i < 20; i++) begin tick; h += int'(pwm_gatilho); end
        n_cmp++;
        if (h !== 3) begin n_err++; $display("FAIL pwm_armed: got %0d high, expected 3", h); end
        armar_disparo = 1'b0; disparar = 1'b1;
        exp_q.push_back(3); exp_q.push_back(4);
        n = 0;
        do begin tick; n++; end while (!fim_disparo && n < 40);
        prev = pwm_gatilho;
        n = 0;
        do begin prev = pwm_gatilho; tick; n++; end while (!(pwm_gatilho && !prev) && n < 60);
        n_cmp++;
        if (n >= 60) begin n_err++; $display("FAIL pwm_sync2: got no period start, expected one within 60"); end
        for (int p = 0; p < 2; p++) begin
            h = int'(pwm_gatilho);
            for (int i = 0; i < 19; i++) begin tick; h += int'(pwm_gatilho); end
            n_cmp++;
            if (h !== 4) begin n_err++; $display("FAIL pwm_fired[%0d]: got %0d high, expected 4", p, h); end
            tick;
        end
        disparar = 1'b0;
        exp_q.push_back(0);
        tick; tick;
    endtask

    task automatic test_reset_mid;
        int n, h;
        refill;
        armar_disparo = 1'b1;
        exp_q.push_back(1); exp_q.push_back(2);
        n = 0;
        do begin tick; n++; end while (!disparo_pronto && n < 40);
        armar_disparo = 1'b0; disparar = 1'b1;
        exp_q.push_back(3); exp_q.push_back(4);
        n = 0;
        do begin tick; n++; end while (!fim_disparo && n < 40);
        n_cmp++;
        if (municao !== 4'd1) begin n_err++; $display("FAIL mid_pre_municao: got %0d, expected 1", municao); end
        disparar = 1'b0;
        exp_q.push_back(0);
        reset = 1'b1;
        #2;
        n_cmp += 6;
        if (db_estado !== 4'd0) begin n_err++; $display("FAIL mid_estado: got %0d, expected 0", db_estado); end
        if (fim_disparo !== 1'b0) begin n_err++; $display("FAIL mid_fim: got %b, expected 0", fim_disparo); end
        if (disparo_pronto !== 1'b0 || disparo_carregado !== 1'b0) begin
            n_err++; $display("FAIL mid_flags: got %b%b, expected 00", disparo_pronto, disparo_carregado);
        end
        if (municao !== 4'd2) begin n_err++; $display("FAIL mid_municao: got %0d, expected 2", municao); end
        if (municao_carregada !== 1'b1) begin n_err++; $display("FAIL mid_mun_carregada: got %b, expected 1", municao_carregada); end
        if (pwm_gatilho !== 1'b0) begin n_err++; $display("FAIL mid_pwm: got %b, expected 0", pwm_gatilho); end
        tick;
        reset = 1'b0;
        h = 0;
        for (int i = 0; i < 20; i++) begin tick; h += int'(pwm_gatilho); end
        n_cmp++;
        if (h !== 2) begin n_err++; $display("FAIL mid_pwm_period: got %0d high, expected 2", h); end
    endtask

    initial begin
        reset              = 1'b1;
        armar_disparo      = 1'b0;
        disparar           = 1'b0;
        recarregar_disparo = 1'b0;
        recarregar_municao = 1'b0;
        test_reset;
        test_full_cycle;
        test_ammo_depletion;
        test_refill_race;
        test_abort;
        test_pwm;
        test_reset_mid;
        tick;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL state_seq_left: got %0d unconsumed, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/torreta_disparador.md
Name: torreta_disparador

Overview:
- Firing-mechanism stage directly downstream of the turret control unit.
- Consumes the control unit's armar_disparo, disparar and recarregar_disparo level commands.
- Drives the trigger servo PWM and tracks the magazine ammunition count.
- Returns the disparo_pronto, fim_disparo, disparo_carregado and municao_carregada status flags to the control unit.

Parameters:
- T_ARMAR, 25000000: cycles the servo dwells moving to the armed position.
- T_DISPARO, 15000000: cycles the servo dwells in the fire position.
- T_RECARGA, 25000000: cycles the servo dwells returning to rest.
- PERIODO_PWM, 1000000: PWM period in cycles (20 ms at 50 MHz).
- LARG_REPOUSO, 50000: pulse width for the rest position.
- LARG_ARMADO, 75000: pulse width for the armed position.
- LARG_DISPARO, 100000: pulse width for the fire position.
- MUNICAO_MAX, 6: magazine capacity, 1..15.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- armar_disparo  in  1  level, held by the control unit while preparing a shot
- disparar  in  1  level, held while firing
- recarregar_disparo  in  1  level, held while re-cocking
- recarregar_municao  in  1  one-cycle pulse from debounced operator input; refills the magazine
- disparo_pronto  out  1  armed and ready to fire
- fim_disparo  out  1  shot completed
- disparo_carregado  out  1  re-cock complete
- municao_carregada  out  1  municao != 0
- municao  out  4  rounds remaining
- pwm_gatilho  out  1  trigger servo PWM
- db_estado  out  4  debug state code

Behaviour:

States and db_estado codes:
- REPOUSO 0, ARMANDO 1, ARMADO 2, DISPARANDO 3, DISPARADO 4, RECARREGANDO 5, CARREGADO 6.

Reset:
- state = REPOUSO, timer = 0, municao = MUNICAO_MAX.
- PWM counter = 0, latched width = LARG_REPOUSO, pwm_gatilho = 0.
- All status flags = 0 except municao_carregada = 1.
- Reset takes effect immediately, mid-operation included.

Timer:
- Single dwell counter, cleared on every state change.
- Increments only in ARMANDO, DISPARANDO and RECARREGANDO.
- A dwell state exits on the edge where timer == T-1, so each dwell state lasts exactly T cycles.

Transitions (evaluated in priority order within each state):
- REPOUSO:
  - disparar -> DISPARANDO.
  - else armar_disparo -> ARMANDO.
  - else recarregar_disparo -> RECARREGANDO.
- ARMANDO:
  - dwell done -> ARMADO.
  - armar_disparo low and disparar low -> REPOUSO (abort).
- ARMADO:
  - disparar -> DISPARANDO.
  - else armar_disparo low -> REPOUSO.
- DISPARANDO:
  - Always completes its dwell (mechanical; command drop ignored), then -> DISPARADO.
- DISPARADO:
  - recarregar_disparo -> RECARREGANDO.
  - else disparar low -> REPOUSO.
- RECARREGANDO:
  - dwell done -> CARREGADO.
  - recarregar_disparo low -> REPOUSO (abort).
- CARREGADO:
  - recarregar_disparo low -> REPOUSO.

Moore outputs:
- disparo_pronto = (ARMADO).
- fim_disparo = (DISPARADO).
- disparo_carregado = (CARREGADO).

Latency:
- armar_disparo first sampled high in REPOUSO at edge k -> disparo_pronto high from edge k+1+T_ARMAR.

Ammunition:
- municao decrements by 1 on the DISPARANDO->DISPARADO edge, saturating at 0.
- Firing with municao = 0 still runs the full mechanical sequence, with no decrement.
- recarregar_municao sets municao = MUNICAO_MAX in any state; if it coincides with a decrement, the refill wins.
- municao_carregada is combinational from municao.

Servo position requested by state:
- LARG_ARMADO in ARMANDO and ARMADO.
- LARG_DISPARO in DISPARANDO and DISPARADO.
- LARG_REPOUSO otherwise.

PWM generation:
- Counter runs 0..PERIODO_PWM-1 and wraps.
- The requested width is latched only when counter == 0, giving glitch-free periods.
- pwm_gatilho is registered: 1 while counter < latched width.
- Width changes take effect at the next period boundary.

Simultaneous commands:
- disparar outranks armar_disparo, which outranks recarregar_disparo.
- Illegal combinations never stall the FSM; the priorities above always resolve them.

Test Plan:
Bench parameters: T_ARMAR=4, T_DISPARO=3, T_RECARGA=5, PERIODO_PWM=20, widths 2/3/4, MUNICAO_MAX=2.
1. Full cycle: armar_disparo high at edge 0, disparar high on disparo_pronto, then recarregar_disparo on fim_disparo -> disparo_pronto high from edge 5; fim_disparo 4 cycles after disparar is sampled; disparo_carregado 6 cycles after recarregar_disparo is sampled; municao 2->1; db_estado sequence 0,1,2,3,4,5,6,0.
2. Two full cycles, then a third -> municao 1->0 and municao_carregada=0; third shot completes with municao held at 0; a recarregar_municao pulse gives municao=2.
3. Refill pulse on the same edge as the DISPARANDO->DISPARADO transition -> municao=2, not 1.
4. armar_disparo drops after 2 cycles in ARMANDO -> REPOUSO, disparo_pronto never asserts; disparar dropped mid-DISPARANDO -> full 3-cycle dwell still runs, then DISPARADO.
5. PWM check: enter ARMANDO mid-period -> current period keeps 2 high cycles; next period has 3 high of 20; DISPARADO periods have 4 high.
6. Reset asserted in DISPARADO with municao=1 -> immediately REPOUSO, all flags 0, municao=2, pwm_gatilho=0; after release the first period has 2 high cycles.
